// File: rtl/logic_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : logic_pipe_pkg
//  Description : Shared definitions for the logic pipeline unit. Holds the
//                3-bit operation encoding used by the operand bus, the
//                pipeline registers and the combinational operation core.
//  Contents    : OP_WIDTH  - width of the operation select field
//                op_e      - operation select encoding
//                op_name   - short mnemonic for an encoding (debug helper)
//  Revision    : 1.0 - initial release
// ============================================================================
package logic_pipe_pkg;

   localparam int OP_WIDTH = 3;

   typedef enum logic [OP_WIDTH-1:0] {
      OP_AND   = 3'b000,   // A & B
      OP_OR    = 3'b001,   // A | B
      OP_NAND  = 3'b010,   // ~(A & B)
      OP_NOR   = 3'b011,   // ~(A | B)
      OP_XOR   = 3'b100,   // A ^ B
      OP_XNOR  = 3'b101,   // ~(A ^ B)
      OP_NOTA  = 3'b110,   // ~A
      OP_PASSA = 3'b111    // A
   } op_e;

   // Packs a three-character mnemonic into a vector; handy for waveform
   // viewers that can display ASCII radix.
   function automatic logic [23:0] op_name(input op_e op);
      logic [23:0] name;
      name = "???";
      case (op)
         OP_AND   : name = "AND";
         OP_OR    : name = "OR ";
         OP_NAND  : name = "NND";
         OP_NOR   : name = "NOR";
         OP_XOR   : name = "XOR";
         OP_XNOR  : name = "XNR";
         OP_NOTA  : name = "NTA";
         OP_PASSA : name = "PSA";
         default  : name = "???";
      endcase
      return name;
   endfunction

endpackage : logic_pipe_pkg
`default_nettype wire

// File: rtl/logic_pipe_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : logic_pipe_unit_if
//  Description : Operand/result bus of the logic pipeline unit. Bundles the
//                unit enable, the upstream operand handshake, the downstream
//                result handshake, result flags and the completion counter.
//  Modports    : master - upstream/downstream environment (drives operands,
//                         enable and out_ready; observes results)
//                slave  - the pipeline unit itself
//  Signals     : EN          unit enable (gates acceptance only)
//                in_valid    operand beat valid
//                in_ready    unit can accept a beat this cycle
//                A, B        operands, DATA_WIDTH bits
//                OP          operation select, OP_WIDTH bits
//                out_valid   result beat valid
//                out_ready   downstream accepts result
//                RESULT      operation result, DATA_WIDTH bits
//                ZERO_FLAG   RESULT is all zeros
//                PARITY_FLAG XOR-reduction of RESULT
//                OP_CNT      results accepted downstream, CNT_WIDTH bits
//  Revision    : 1.0 - initial release
// ============================================================================
interface logic_pipe_unit_if #(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 8
);
   import logic_pipe_pkg::*;

   logic                  EN;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] A;
   logic [DATA_WIDTH-1:0] B;
   logic [OP_WIDTH-1:0]   OP;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] RESULT;
   logic                  ZERO_FLAG;
   logic                  PARITY_FLAG;
   logic [CNT_WIDTH-1:0]  OP_CNT;

   modport master (
      output EN, in_valid, A, B, OP, out_ready,
      input  in_ready, out_valid, RESULT, ZERO_FLAG, PARITY_FLAG, OP_CNT
   );

   modport slave (
      input  EN, in_valid, A, B, OP, out_ready,
      output in_ready, out_valid, RESULT, ZERO_FLAG, PARITY_FLAG, OP_CNT
   );

endinterface : logic_pipe_unit_if
`default_nettype wire

// File: rtl/logic_pipe_unit_op_core.sv
`default_nettype none
// ============================================================================
//  Module      : logic_op_core
//  Description : Purely combinational bitwise operation decoder. Sits between
//                the operand stage and the result stage of logic_pipe_unit.
//  Parameters  : DATA_WIDTH - operand/result width
//  Ports       : a      in   DATA_WIDTH  operand A
//                b      in   DATA_WIDTH  operand B
//                op     in   op_e        operation select
//                result out  DATA_WIDTH  operation result
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_op_core
   import logic_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  op_e                   op,
   output logic [DATA_WIDTH-1:0] result
);

   always_comb begin
      result = a;
      case (op)
         OP_AND   : result = a & b;
         OP_OR    : result = a | b;
         OP_NAND  : result = ~(a & b);
         OP_NOR   : result = ~(a | b);
         OP_XOR   : result = a ^ b;
         OP_XNOR  : result = ~(a ^ b);
         OP_NOTA  : result = ~a;
         OP_PASSA : result = a;
         default  : result = a;
      endcase
   end

endmodule : logic_op_core
`default_nettype wire

// File: rtl/logic_pipe_unit.sv
`default_nettype none
// ============================================================================
//  Module      : logic_pipe_unit
//  Description : Two-stage valid/ready pipeline applying a bitwise operation
//                to two operands. Stage 1 captures A, B, OP on acceptance;
//                stage 2 captures the result plus zero/parity flags. Results
//                handed downstream are counted in a wrapping counter.
//  Parameters  : DATA_WIDTH - operand/result width
//                CNT_WIDTH  - completed-operation counter width
//  Ports       : CLK  in   rising-edge clock
//                RST  in   asynchronous active-low reset
//                bus  slave modport of logic_pipe_unit_if (operand and
//                     result handshakes, flags, counter, enable)
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_pipe_unit
   import logic_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 8
) (
   input  logic             CLK,
   input  logic             RST,
   logic_pipe_unit_if.slave bus
);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic                  r_run;        // set on the first edge after reset
   logic                  r_s1_valid;
   logic [DATA_WIDTH-1:0] r_s1_a;
   logic [DATA_WIDTH-1:0] r_s1_b;
   op_e                   r_s1_op;
   logic                  r_s2_valid;
   logic [DATA_WIDTH-1:0] r_result;
   logic                  r_zero;
   logic                  r_parity;
   logic [CNT_WIDTH-1:0]  r_op_cnt;

   logic                  w_s2_xfer;
   logic                  w_s1_adv;
   logic                  w_s2_load;
   logic                  w_in_ready;
   logic                  w_accept;
   logic [DATA_WIDTH-1:0] w_core_result;

   // ------------------------------------------------------------------------
   // Handshake control
   // ------------------------------------------------------------------------
   // Stage 2 frees up either because it is empty or because its beat leaves
   // this cycle, which lets stage 1 move forward and in turn lets a new beat
   // in. The chain is combinational so a full pipeline still streams one
   // beat per cycle while out_ready stays high.
   assign w_s2_xfer  = r_s2_valid && bus.out_ready;
   assign w_s1_adv   = !r_s2_valid || w_s2_xfer;
   assign w_s2_load  = r_s1_valid && w_s1_adv;

   // r_run is cleared asynchronously by reset and only set by a clock edge,
   // so in_ready stays low during reset and until the first edge after it.
   assign w_in_ready = r_run && bus.EN && (!r_s1_valid || w_s1_adv);
   assign w_accept   = bus.in_valid && w_in_ready;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_run <= 1'b0;
      end else begin
         r_run <= 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Stage 1: operand registers
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_op    <= OP_AND;
      end else begin
         if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= bus.A;
            r_s1_b     <= bus.B;
            r_s1_op    <= op_e'(bus.OP);
         end else if (w_s1_adv) begin
            // Either already empty or the held beat moves into stage 2.
            r_s1_valid <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Operation decode between the stages
   // ------------------------------------------------------------------------
   logic_op_core #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_op_core (
      .a      (r_s1_a),
      .b      (r_s1_b),
      .op     (r_s1_op),
      .result (w_core_result)
   );

   // ------------------------------------------------------------------------
   // Stage 2: result and flag registers
   // ------------------------------------------------------------------------
   // RESULT and flags only change when a new beat is loaded, so they hold
   // their last value across idle cycles and stay stable under back-pressure.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_s2_valid <= 1'b0;
         r_result   <= '0;
         r_zero     <= 1'b0;
         r_parity   <= 1'b0;
      end else begin
         if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_result   <= w_core_result;
            r_zero     <= (w_core_result == '0);
            r_parity   <= ^w_core_result;
         end else if (w_s2_xfer) begin
            r_s2_valid <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Completed-operation counter (wraps silently)
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_op_cnt <= '0;
      end else if (w_s2_xfer) begin
         r_op_cnt <= r_op_cnt + CNT_WIDTH'(1);
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = r_s2_valid;
   assign bus.RESULT      = r_result;
   assign bus.ZERO_FLAG   = r_zero;
   assign bus.PARITY_FLAG = r_parity;
   assign bus.OP_CNT      = r_op_cnt;

endmodule : logic_pipe_unit
`default_nettype wire

// File: tb/tb_logic_pipe_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_pipe_unit
//  Description : Directed self-checking bench for logic_pipe_unit. A default
//                instance (CNT_WIDTH=8) covers reset, latency, operations,
//                back-pressure, in-flight reset and enable gating; a second
//                instance (CNT_WIDTH=4) covers counter wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_pipe_unit;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   logic_pipe_unit_if #(.DATA_WIDTH(16), .CNT_WIDTH(8)) bus  ();
   logic_pipe_unit_if #(.DATA_WIDTH(16), .CNT_WIDTH(4)) bus4 ();

   logic_pipe_unit #(.DATA_WIDTH(16), .CNT_WIDTH(8)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   logic_pipe_unit #(.DATA_WIDTH(16), .CNT_WIDTH(4)) dut4 (
      .CLK (CLK),
      .RST (RST),
      .bus (bus4)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      bus.EN = 1'b1;  bus.in_valid = 1'b0;  bus.out_ready = 1'b1;
      bus.A = '0;     bus.B = '0;           bus.OP = 3'b000;
      bus4.EN = 1'b1; bus4.in_valid = 1'b0; bus4.out_ready = 1'b1;
      bus4.A = '0;    bus4.B = '0;          bus4.OP = 3'b000;
   endtask

   task automatic apply_reset();
      RST = 1'b0;
      idle_inputs();
      tick();
      tick();
      RST = 1'b1;
      tick();
   endtask

   // Reset values, and in_ready held off until the first edge after release.
   task automatic test_reset();
      idle_inputs();
      #2 RST = 1'b0;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
      n_checks++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
      n_checks++;
      if (bus.RESULT !== 16'h0000) begin n_fail++; $display("FAIL rst_result: got %h expected 0000", bus.RESULT); end
      n_checks++;
      if ({bus.ZERO_FLAG, bus.PARITY_FLAG} !== 2'b00) begin n_fail++; $display("FAIL rst_flags: got %b expected 00", {bus.ZERO_FLAG, bus.PARITY_FLAG}); end
      n_checks++;
      if (bus.OP_CNT !== 8'd0) begin n_fail++; $display("FAIL rst_op_cnt: got %0d expected 0", bus.OP_CNT); end
      n_checks++;
      if (bus4.OP_CNT !== 4'd0) begin n_fail++; $display("FAIL rst_op_cnt4: got %0d expected 0", bus4.OP_CNT); end
      tick();
      tick();
      RST = 1'b1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL release_ready_early: got %b expected 0", bus.in_ready); end
      tick();
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready_edge: got %b expected 1", bus.in_ready); end
   endtask

   // Single beats: latency, result, flags, hold after transfer.
   task automatic test_single_ops();
      logic [15:0] ta [3];
      logic [15:0] tb [3];
      logic [2:0]  top [3];
      logic [15:0] tres [3];
      logic        tzero [3];
      logic        tpar [3];
      ta   = '{16'hF0F0, 16'h1234, 16'h0000};
      tb   = '{16'hFF00, 16'h1234, 16'h5A5A};
      top  = '{3'b100,   3'b100,   3'b110};
      tres = '{16'h0FF0, 16'h0000, 16'hFFFF};
      tzero = '{1'b0, 1'b1, 1'b0};
      tpar  = '{1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 3; i++) begin
         bus.A = ta[i]; bus.B = tb[i]; bus.OP = top[i];
         bus.in_valid = 1'b1; bus.out_ready = 1'b1;
         #1;
         n_checks++;
         if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL single%0d_in_ready: got %b expected 1", i, bus.in_ready); end
         tick();
         bus.in_valid = 1'b0;
         n_checks++;
         if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single%0d_early_valid: got %b expected 0", i, bus.out_valid); end
         tick();
         n_checks++;
         if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single%0d_out_valid: got %b expected 1", i, bus.out_valid); end
         n_checks++;
         if (bus.RESULT !== tres[i]) begin n_fail++; $display("FAIL single%0d_result: got %h expected %h", i, bus.RESULT, tres[i]); end
         n_checks++;
         if (bus.ZERO_FLAG !== tzero[i]) begin n_fail++; $display("FAIL single%0d_zero: got %b expected %b", i, bus.ZERO_FLAG, tzero[i]); end
         n_checks++;
         if (bus.PARITY_FLAG !== tpar[i]) begin n_fail++; $display("FAIL single%0d_parity: got %b expected %b", i, bus.PARITY_FLAG, tpar[i]); end
         tick();
         n_checks++;
         if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single%0d_drop_valid: got %b expected 0", i, bus.out_valid); end
         n_checks++;
         if (bus.RESULT !== tres[i]) begin n_fail++; $display("FAIL single%0d_hold: got %h expected %h", i, bus.RESULT, tres[i]); end
      end
      n_checks++;
      if (bus.OP_CNT !== 8'd3) begin n_fail++; $display("FAIL single_op_cnt: got %0d expected 3", bus.OP_CNT); end
   endtask

   // Eight streamed beats, out_ready low on cycles 3..6.
   task automatic test_back_to_back();
      logic [15:0] ta [8];
      logic [15:0] tb [8];
      logic [15:0] tres [8];
      logic        tzero [8];
      logic        tpar [8];
      int sent;
      int got;
      logic exp_ready;
      ta   = '{16'h00FF, 16'h1200, 16'hFFFF, 16'h8000, 16'hAAAA, 16'hAAAA, 16'h0001, 16'h0007};
      tb   = '{16'h0F0F, 16'h0034, 16'h0001, 16'h0001, 16'h5555, 16'h5555, 16'h1234, 16'hFFFF};
      tres = '{16'h000F, 16'h1234, 16'hFFFE, 16'h7FFE, 16'hFFFF, 16'h0000, 16'hFFFE, 16'h0007};
      tzero = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tpar  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      apply_reset();
      sent = 0;
      got  = 0;
      for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
         bus.out_ready = !(cyc >= 3 && cyc <= 6);
         bus.in_valid  = (sent < 8);
         if (sent < 8) begin
            bus.A = ta[sent]; bus.B = tb[sent]; bus.OP = 3'(sent);
         end
         #1;
         exp_ready = !(cyc >= 3 && cyc <= 6);
         n_checks++;
         if (bus.in_ready !== exp_ready) begin n_fail++; $display("FAIL b2b_in_ready c%0d: got %b expected %b", cyc, bus.in_ready, exp_ready); end
         if (bus.out_valid === 1'b1) begin
            n_checks++;
            if (bus.RESULT !== tres[got] || bus.ZERO_FLAG !== tzero[got] || bus.PARITY_FLAG !== tpar[got]) begin
               n_fail++;
               $display("FAIL b2b_beat%0d c%0d: got %h/z%b/p%b expected %h/z%b/p%b", got, cyc,
                        bus.RESULT, bus.ZERO_FLAG, bus.PARITY_FLAG, tres[got], tzero[got], tpar[got]);
            end
            if (bus.out_ready) got++;
         end
         if (bus.in_valid && bus.in_ready) sent++;
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      n_checks++;
      if (got !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", got); end
      n_checks++;
      if (bus.OP_CNT !== 8'd8) begin n_fail++; $display("FAIL b2b_op_cnt: got %0d expected 8", bus.OP_CNT); end
   endtask

   // Reset asserted with two beats in flight.
   task automatic test_reset_inflight();
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.A = 16'h0007; bus.B = 16'h0000; bus.OP = 3'b111;
      tick();
      bus.A = 16'h0001; bus.OP = 3'b110;
      tick();
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.RESULT !== 16'h0007 || bus.PARITY_FLAG !== 1'b1) begin
         n_fail++;
         $display("FAIL inflight_pre: got v%b %h p%b expected v1 0007 p1", bus.out_valid, bus.RESULT, bus.PARITY_FLAG);
      end
      #2 RST = 1'b0;
      #1;
      n_checks++;
      if ({bus.in_ready, bus.out_valid, bus.ZERO_FLAG, bus.PARITY_FLAG} !== 4'b0000) begin
         n_fail++;
         $display("FAIL inflight_rst_ctrl: got %b expected 0000", {bus.in_ready, bus.out_valid, bus.ZERO_FLAG, bus.PARITY_FLAG});
      end
      n_checks++;
      if (bus.RESULT !== 16'h0000) begin n_fail++; $display("FAIL inflight_rst_result: got %h expected 0000", bus.RESULT); end
      n_checks++;
      if (bus.OP_CNT !== 8'd0) begin n_fail++; $display("FAIL inflight_rst_op_cnt: got %0d expected 0", bus.OP_CNT); end
      tick();
      tick();
      RST = 1'b1;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         n_checks++;
         if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL inflight_stale c%0d: got %b expected 0", c, bus.out_valid); end
      end
   endtask

   // EN dropped after one accept: in_ready low, pending beat still drains.
   task automatic test_en_gate();
      int n;
      bus.EN = 1'b1; bus.out_ready = 1'b1;
      bus.in_valid = 1'b1; bus.A = 16'h00FF; bus.B = 16'h0F0F; bus.OP = 3'b000;
      tick();
      bus.EN = 1'b0; bus.A = 16'hFFFF; bus.OP = 3'b111;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL en_in_ready: got %b expected 0", bus.in_ready); end
      n = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (bus.out_valid === 1'b1) begin
            n++;
            n_checks++;
            if (bus.RESULT !== 16'h000F) begin n_fail++; $display("FAIL en_result: got %h expected 000F", bus.RESULT); end
         end
      end
      n_checks++;
      if (n !== 1) begin n_fail++; $display("FAIL en_beats: got %0d expected 1", n); end
      n_checks++;
      if (bus.OP_CNT !== 8'd1) begin n_fail++; $display("FAIL en_op_cnt: got %0d expected 1", bus.OP_CNT); end
      bus.in_valid = 1'b0;
      bus.EN = 1'b1;
   endtask

   // 17 transfers through the 4-bit counter instance.
   task automatic test_wrap();
      int sent;
      int got;
      bit seen16;
      sent = 0; got = 0; seen16 = 1'b0;
      bus4.EN = 1'b1; bus4.out_ready = 1'b1;
      bus4.A = 16'h3C3C; bus4.B = 16'h00FF; bus4.OP = 3'b001;
      for (int cyc = 0; cyc < 80 && got < 17; cyc++) begin
         bus4.in_valid = (sent < 17);
         #1;
         if (bus4.in_valid && bus4.in_ready) sent++;
         if (bus4.out_valid && bus4.out_ready) got++;
         tick();
         if (got == 16 && !seen16) begin
            seen16 = 1'b1;
            n_checks++;
            if (bus4.OP_CNT !== 4'd0) begin n_fail++; $display("FAIL wrap_at16: got %0d expected 0", bus4.OP_CNT); end
         end
      end
      bus4.in_valid = 1'b0;
      n_checks++;
      if (got !== 17) begin n_fail++; $display("FAIL wrap_transfers: got %0d expected 17", got); end
      n_checks++;
      if (bus4.OP_CNT !== 4'd1) begin n_fail++; $display("FAIL wrap_op_cnt: got %0d expected 1", bus4.OP_CNT); end
   endtask

   initial begin
      test_reset();
      test_single_ops();
      test_back_to_back();
      test_reset_inflight();
      test_en_gate();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_logic_pipe_unit
`default_nettype wire

// File: doc/logic_pipe_unit.md
LOGIC_PIPE_UNIT -- requirements
Module: logic_pipe_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, operand/result width.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, completed-operation counter width.
REQ-003 SHALL have port CLK  input  1  rising-edge clock.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port EN  input  1  unit enable; gates input acceptance only.
REQ-006 SHALL have port in_valid  input  1  operand beat valid.
REQ-007 SHALL have port in_ready  output  1  unit can accept a beat this cycle.
REQ-008 SHALL have port A  input  DATA_WIDTH  signed operand A.
REQ-009 SHALL have port B  input  DATA_WIDTH  signed operand B.
REQ-010 SHALL have port OP  input  3  operation select.
REQ-011 SHALL have port out_valid  output  1  result beat valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port RESULT  output  DATA_WIDTH  operation result.
REQ-014 SHALL have port ZERO_FLAG  output  1  RESULT all zeros.
REQ-015 SHALL have port PARITY_FLAG  output  1  XOR-reduction of RESULT.
REQ-016 SHALL have port OP_CNT  output  CNT_WIDTH  count of results accepted downstream.

Function
REQ-017 SHALL implement OP: 000 A&B, 001 A|B, 010 ~(A&B), 011 ~(A|B), 100 A^B, 101 ~(A^B), 110 ~A, 111 A (pass).
REQ-018 SHALL be a two-stage pipeline: stage 1 registers A, B, OP on accept; stage 2 registers RESULT and flags computed from stage-1 contents.
REQ-019 SHALL accept a beat when in_valid && in_ready at a rising edge; SHALL produce out_valid exactly 2 cycles later absent back-pressure.
REQ-020 SHALL transfer a result when out_valid && out_ready at a rising edge.
REQ-021 SHALL drive in_ready = EN && (stage1 empty || stage1 advancing); stage1 advances when stage2 empty or stage2 transferring.
REQ-022 SHALL sustain one beat per cycle with out_ready held high.
REQ-023 SHALL, under out_ready low, hold RESULT, flags, out_valid stable until transfer; stage 1 SHALL hold its beat; no beat lost or duplicated.
REQ-024 SHALL, with EN low, deassert in_ready while in-flight beats continue to drain normally.
REQ-025 SHALL compute ZERO_FLAG and PARITY_FLAG from the same registered RESULT, valid only while out_valid is high.
REQ-026 SHALL increment OP_CNT by 1 per downstream transfer, wrapping 2^CNT_WIDTH-1 -> 0 without flag.
REQ-027 SHALL hold RESULT and flags at last values when out_valid is low (no zeroing between beats).
REQ-028 SHALL, on simultaneous accept and transfer, perform both in the same cycle with correct ordering.

Reset
REQ-029 SHALL, while RST low, force in_ready=0, out_valid=0, RESULT=0, ZERO_FLAG=0, PARITY_FLAG=0, OP_CNT=0, both stage-valid bits=0, asynchronously.
REQ-030 SHALL discard all in-flight beats on reset assertion mid-operation; no result emitted after release for pre-reset beats.
REQ-031 SHALL raise in_ready no earlier than the first rising edge after RST deasserts (with EN high).

Structure
REQ-032 SHALL place OP encodings (3-bit constants/enum) in shared package logic_pipe_pkg.
REQ-033 SHALL place the combinational operation decode in sub-module logic_op_core (A, B, OP -> result), instantiated between stages.
REQ-034 SHALL contain no latches; all state in CLK-domain flops with async RST.

Verification
REQ-035 SHALL cover: DATA_WIDTH=16, A=16'hF0F0, B=16'hFF00, OP=100 -> RESULT=16'h0FF0, ZERO_FLAG=0, PARITY_FLAG=0, out_valid 2 cycles after accept.
REQ-036 SHALL cover: A=B=16'h1234, OP=100 -> RESULT=0, ZERO_FLAG=1; OP=110 A=16'h0000 -> RESULT=16'hFFFF.
REQ-037 SHALL cover: 8 back-to-back beats (all OPs), out_ready low cycles 3-6 -> in_ready low once both stages full, all 8 results in order, OP_CNT=8.
REQ-038 SHALL cover: CNT_WIDTH=4, 17 transfers -> OP_CNT=1 (wrap).
REQ-039 SHALL cover: RST low with two beats in flight -> all outputs 0 immediately; after release no stale out_valid.
REQ-040 SHALL cover: EN low after one accept -> in_ready=0, pending beat still emerges with out_valid.
